// File: rtl/switch_allocator.sv
// Round-robin switch allocator for the 4x4 mesh crossbar.
// Each output arbitrates among inputs requesting it; a connection persists until its input releases it.
module switch_allocator #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*SEL_W-1:0]   req_dest,
    input  logic [N-1:0]         release_req,
    output logic [N-1:0]         grant,
    output logic [N*SEL_W-1:0]   switch_state,
    output logic [N-1:0]         out_busy,
    output logic [N*SEL_W-1:0]   out_owner
);

    logic [N-1:0]            w_grant;
    logic [N-1:0]            w_busy;
    logic [N-1:0]            w_eligible;
    logic [N-1:0]            w_rel;
    logic [N-1:0]            w_win;
    logic [N-1:0][SEL_W-1:0] w_dest;
    logic [N-1:0][SEL_W-1:0] w_sel;
    logic [N-1:0][SEL_W-1:0] w_owner;
    logic [N-1:0][SEL_W-1:0] w_win_idx;

    assign w_dest     = req_dest;
    assign w_eligible = req_valid & ~w_grant;
    assign w_rel      = release_req & w_grant;

    genvar gi;

    // Output side: busy flag, owner and round-robin pointer per output.
    generate
        for (gi = 0; gi < N; gi++) begin : g_out
            logic             r_busy;
            logic [SEL_W-1:0] r_owner;
            logic [SEL_W-1:0] r_rr;
            logic             w_hit;
            logic [SEL_W-1:0] w_idx;
            logic             w_free;

            // A busy output is never re-arbitrated, so a freed output waits one edge.
            always_comb begin
                int j;
                j     = 0;
                w_hit = 1'b0;
                w_idx = '0;
                if (!r_busy) begin
                    for (int k = 0; k < N; k++) begin
                        j = (int'(r_rr) + k) % N;
                        if (!w_hit && w_eligible[j] && (w_dest[j] == SEL_W'(gi))) begin
                            w_hit = 1'b1;
                            w_idx = SEL_W'(j);
                        end
                    end
                end
            end

            always_comb begin
                w_free = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (w_rel[i] && (w_sel[i] == SEL_W'(gi))) begin
                        w_free = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_busy  <= 1'b0;
                    r_owner <= '0;
                    r_rr    <= '0;
                end else if (w_hit) begin
                    r_busy  <= 1'b1;
                    r_owner <= w_idx;
                    r_rr    <= SEL_W'((int'(w_idx) + 1) % N);
                end else if (w_free) begin
                    r_busy  <= 1'b0;
                end
            end

            assign w_win[gi]     = w_hit;
            assign w_win_idx[gi] = w_idx;
            assign w_busy[gi]    = r_busy;
            assign w_owner[gi]   = r_owner;
        end
    endgenerate

    // Input side: grant level and connected output per input.
    generate
        for (gi = 0; gi < N; gi++) begin : g_in
            logic             r_grant;
            logic [SEL_W-1:0] r_sel;
            logic             w_take;
            logic [SEL_W-1:0] w_take_dest;

            // An input requests a single output, so at most one arbiter can pick it.
            always_comb begin
                w_take      = 1'b0;
                w_take_dest = '0;
                for (int o = 0; o < N; o++) begin
                    if (w_win[o] && (w_win_idx[o] == SEL_W'(gi))) begin
                        w_take      = 1'b1;
                        w_take_dest = SEL_W'(o);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_grant <= 1'b0;
                    r_sel   <= '0;
                end else if (w_rel[gi]) begin
                    r_grant <= 1'b0;
                end else if (w_take) begin
                    r_grant <= 1'b1;
                    r_sel   <= w_take_dest;
                end
            end

            assign w_grant[gi] = r_grant;
            assign w_sel[gi]   = r_sel;
        end
    endgenerate

    assign grant        = w_grant;
    assign switch_state = w_sel;
    assign out_busy     = w_busy;
    assign out_owner    = w_owner;

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: the driver queues hand-computed post-edge state,
// the monitor pops one entry after every active edge and compares.
module tb_switch_allocator;

    logic       clk;
    logic       rst;
    logic [3:0] req_valid;
    logic [7:0] req_dest;
    logic [3:0] release_req;
    logic [3:0] grant;
    logic [7:0] switch_state;
    logic [3:0] out_busy;
    logic [7:0] out_owner;

    int checks;
    int errors;

    typedef struct {
        string      name;
        logic [3:0] g;
        logic [7:0] sel;
        logic [3:0] b;
        logic [7:0] own;
    } exp_t;

    exp_t exp_q[$];

    switch_allocator #(.N(4), .SEL_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_dest     (req_dest),
        .release_req  (release_req),
        .grant        (grant),
        .switch_state (switch_state),
        .out_busy     (out_busy),
        .out_owner    (out_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs per-port indices as {port3, port2, port1, port0}.
    function automatic logic [7:0] pk(input logic [1:0] d3, input logic [1:0] d2,
                                      input logic [1:0] d1, input logic [1:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic step(input string nm, input logic rs, input logic [3:0] rv,
                        input logic [7:0] dst, input logic [3:0] rl,
                        input logic [3:0] eg, input logic [7:0] es,
                        input logic [3:0] eb, input logic [7:0] eo);
        exp_t e;
        @(negedge clk);
        rst         = rs;
        req_valid   = rv;
        req_dest    = dst;
        release_req = rl;
        e.name = nm;
        e.g    = eg;
        e.sel  = es;
        e.b    = eb;
        e.own  = eo;
        exp_q.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (grant !== e.g) begin
                    errors++;
                    $display("FAIL %s grant: got %b expected %b", e.name, grant, e.g);
                end
                checks++;
                if (switch_state !== e.sel) begin
                    errors++;
                    $display("FAIL %s switch_state: got %h expected %h", e.name, switch_state, e.sel);
                end
                checks++;
                if (out_busy !== e.b) begin
                    errors++;
                    $display("FAIL %s out_busy: got %b expected %b", e.name, out_busy, e.b);
                end
                checks++;
                if (out_owner !== e.own) begin
                    errors++;
                    $display("FAIL %s out_owner: got %h expected %h", e.name, out_owner, e.own);
                end
                $display("txn %s: grant=%b sel=%h busy=%b owner=%h", e.name, grant, switch_state, out_busy, out_owner);
            end
        end
    end

    // Driver
    initial begin
        logic [7:0] d_par;
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        req_valid   = '0;
        req_dest    = '0;
        release_req = '0;
        d_par = pk(2'd1, 2'd0, 2'd3, 2'd2);

        // Reset with all requests pending, then parallel grants.
        step("rst0", 1'b0, 4'b1111, d_par, 4'b0000, 4'b0000, 8'h00, 4'b0000, 8'h00);
        step("rst1", 1'b0, 4'b1111, d_par, 4'b0000, 4'b0000, 8'h00, 4'b0000, 8'h00);
        step("par",  1'b1, 4'b1111, d_par, 4'b0000, 4'b1111, d_par, 4'b1111, d_par);
        step("rel3", 1'b1, 4'b0111, d_par, 4'b1000, 4'b0111, d_par, 4'b1101, d_par);
        step("midrst", 1'b0, 4'b0111, d_par, 4'b0000, 4'b0000, 8'h00, 4'b0000, 8'h00);
        step("idle", 1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0000, 8'h00);

        // Single request: input 2 -> output 3.
        step("single",  1'b1, 4'b0100, pk(0,3,0,0), 4'b0000, 4'b0100, pk(0,3,0,0), 4'b1000, pk(2,0,0,0));
        step("hold",    1'b1, 4'b0000, pk(0,3,0,0), 4'b0000, 4'b0100, pk(0,3,0,0), 4'b1000, pk(2,0,0,0));
        step("relsgl",  1'b1, 4'b0000, pk(0,3,0,0), 4'b0100, 4'b0000, pk(0,3,0,0), 4'b0000, pk(2,0,0,0));
        step("relidle", 1'b1, 4'b0000, pk(0,3,0,0), 4'b0100, 4'b0000, pk(0,3,0,0), 4'b0000, pk(2,0,0,0));

        // Round robin on output 1 among inputs 0, 1, 3.
        step("rr_g0a", 1'b1, 4'b1011, pk(1,0,1,1), 4'b0000, 4'b0001, pk(0,3,0,1), 4'b0010, pk(2,0,0,0));
        step("rr_r0a", 1'b1, 4'b1011, pk(1,0,1,1), 4'b0001, 4'b0000, pk(0,3,0,1), 4'b0000, pk(2,0,0,0));
        step("rr_g1a", 1'b1, 4'b1011, pk(1,0,1,1), 4'b0000, 4'b0010, pk(0,3,1,1), 4'b0010, pk(2,0,1,0));
        step("rr_r1a", 1'b1, 4'b1011, pk(1,0,1,1), 4'b0010, 4'b0000, pk(0,3,1,1), 4'b0000, pk(2,0,1,0));
        step("rr_g3a", 1'b1, 4'b1011, pk(1,0,1,1), 4'b0000, 4'b1000, pk(1,3,1,1), 4'b0010, pk(2,0,3,0));
        step("rr_r3a", 1'b1, 4'b1011, pk(1,0,1,1), 4'b1000, 4'b0000, pk(1,3,1,1), 4'b0000, pk(2,0,3,0));
        step("rr_g0b", 1'b1, 4'b1011, pk(1,0,1,1), 4'b0000, 4'b0001, pk(1,3,1,1), 4'b0010, pk(2,0,0,0));
        step("rr_r0b", 1'b1, 4'b1011, pk(1,0,1,1), 4'b0001, 4'b0000, pk(1,3,1,1), 4'b0000, pk(2,0,0,0));
        step("rr_g1b", 1'b1, 4'b1011, pk(1,0,1,1), 4'b0000, 4'b0010, pk(1,3,1,1), 4'b0010, pk(2,0,1,0));
        step("rr_r1b", 1'b1, 4'b1011, pk(1,0,1,1), 4'b0010, 4'b0000, pk(1,3,1,1), 4'b0000, pk(2,0,1,0));
        step("rr_g3b", 1'b1, 4'b1011, pk(1,0,1,1), 4'b0000, 4'b1000, pk(1,3,1,1), 4'b0010, pk(2,0,3,0));
        step("rr_r3b", 1'b1, 4'b0000, pk(1,0,1,1), 4'b1000, 4'b0000, pk(1,3,1,1), 4'b0000, pk(2,0,3,0));

        // Busy hold and withdrawal on output 0.
        step("own0", 1'b1, 4'b0001, pk(0,0,0,0), 4'b0000, 4'b0001, pk(1,3,1,0), 4'b0001, pk(2,0,3,0));
        for (int c = 0; c < 5; c++) begin
            step("busywait", 1'b1, 4'b0010, pk(0,0,0,0), 4'b0000, 4'b0001, pk(1,3,1,0), 4'b0001, pk(2,0,3,0));
        end
        step("withdraw", 1'b1, 4'b0000, pk(0,0,0,0), 4'b0000, 4'b0001, pk(1,3,1,0), 4'b0001, pk(2,0,3,0));
        step("rel0",     1'b1, 4'b0000, pk(0,0,0,0), 4'b0001, 4'b0000, pk(1,3,1,0), 4'b0000, pk(2,0,3,0));
        step("free0a",   1'b1, 4'b0000, pk(0,0,0,0), 4'b0000, 4'b0000, pk(1,3,1,0), 4'b0000, pk(2,0,3,0));
        step("free0b",   1'b1, 4'b0000, pk(0,0,0,0), 4'b0000, 4'b0000, pk(1,3,1,0), 4'b0000, pk(2,0,3,0));

        // Drain the scoreboard with a bounded wait.
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
